// File: rtl/ice_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ice_slave_arbiter
// Purpose  : ICE slave output bus arbiter with fixed-priority / round-robin
//            policy, one-cycle turnaround and optional hold watchdog
//            (enabled by defining ICE_ARB_WATCHDOG_EN).
// Revision : 1.0 - initial release
// ============================================================================
module ice_slave_arbiter #(
  parameter int NUM_DEV  = 7,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rr_mode,
  input  logic [NUM_DEV-1:0] arb_request,
  output logic [NUM_DEV-1:0] arb_grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               timeout_evt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]   c_IDX_RST = IDX_W'(NUM_DEV - 1);
  localparam logic [NUM_DEV-1:0] c_ONE     = NUM_DEV'(1);

  if (NUM_DEV < 2 || NUM_DEV > 16 || NUM_DEV > (1 << IDX_W) ||
      MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_param_check
    $error("ice_slave_arbiter: illegal parameter combination");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_DEV-1:0]   r_grant;
  logic [NUM_DEV-1:0]   w_grant_nxt;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 r_busy;
  logic [NUM_DEV-1:0]   w_lockout;
  logic [NUM_DEV-1:0]   w_eligible;
  logic                 w_owner_req;
  logic                 w_hold_expired;
  logic                 w_lo_any;
  logic                 w_hi_any;
  logic [IDX_W-1:0]     w_lo_idx;
  logic [IDX_W-1:0]     w_hi_idx;
  logic [IDX_W-1:0]     w_win_idx;
  logic [NUM_DEV-1:0]   w_win_onehot;

  assign w_eligible   = arb_request & ~w_lockout;
  assign w_owner_req  = |(arb_request & r_grant);

  // Lowest eligible overall, and lowest eligible above the pointer; the
  // round-robin winner is the latter unless empty (wrap to the bottom).
  always_comb begin
    w_lo_any = 1'b0;
    w_hi_any = 1'b0;
    w_lo_idx = '0;
    w_hi_idx = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = IDX_W'(i);
        if (IDX_W'(i) > r_grant_idx) begin
          w_hi_any = 1'b1;
          w_hi_idx = IDX_W'(i);
        end
      end
    end
  end

  assign w_win_idx    = (rr_mode && w_hi_any) ? w_hi_idx : w_lo_idx;
  assign w_win_onehot = c_ONE << w_win_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_grant_idx;
    case (r_state)
      S_IDLE: begin
        if (w_lo_any) begin
          w_grant_nxt = w_win_onehot;
          w_idx_nxt   = w_win_idx;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!w_owner_req || w_hold_expired) begin
          w_grant_nxt = '0;
          w_state_nxt = S_TURN;
        end
      end
      S_TURN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant     <= '0;
      r_grant_idx <= c_IDX_RST;
      r_busy      <= 1'b0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_idx_nxt;
      r_busy      <= |w_grant_nxt;
    end
  end

`ifdef ICE_ARB_WATCHDOG_EN
  localparam logic [16:0] c_HOLD_LIM = 17'(MAX_HOLD);

  logic [15:0]        r_hold_cnt;
  logic [NUM_DEV-1:0] r_lockout;
  logic               r_timeout;
  logic               w_timeout_nxt;

  assign w_hold_expired = (r_state == S_GRANT) &&
                          (({1'b0, r_hold_cnt} + 17'd1) >= c_HOLD_LIM);
  assign w_timeout_nxt  = (r_state == S_GRANT) && w_owner_req && w_hold_expired;
  assign w_lockout      = r_lockout;

  // A locked-out slave is released once it is seen with its request low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_lockout  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout_nxt;
      r_lockout <= (r_lockout & arb_request) | (w_timeout_nxt ? r_grant : '0);
      if (r_state == S_GRANT) begin
        if (r_hold_cnt != 16'hFFFF) begin
          r_hold_cnt <= r_hold_cnt + 16'd1;
        end
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  assign timeout_evt = r_timeout;
`else
  assign w_hold_expired = 1'b0;
  assign w_lockout      = '0;
  assign timeout_evt    = 1'b0;
`endif

  assign arb_grant = r_grant;
  assign grant_idx = r_grant_idx;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ice_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ice_slave_arbiter
// Purpose  : Directed self-checking bench for ice_slave_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ice_slave_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       rr_mode;
  logic [6:0] arb_request;
  logic [6:0] arb_grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout_evt;

  int errors = 0;
  int checks = 0;

  ice_slave_arbiter #(
    .NUM_DEV  (7),
    .IDX_W    (3),
    .MAX_HOLD (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rr_mode     (rr_mode),
    .arb_request (arb_request),
    .arb_grant   (arb_grant),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] o;
    logic [2:0] nx;
    logic       held_ok;
    logic       to_seen;

    reset       = 1'b1;
    rr_mode     = 1'b0;
    arb_request = '0;
    step();
    step();
    chk("rst_grant", 32'(arb_grant), 32'h0);
    chk("rst_idx", 32'(grant_idx), 32'd6);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tevt", 32'(timeout_evt), 32'h0);
    reset = 1'b0;
    step();
    chk("idle_nogrant", 32'(arb_grant), 32'h0);

    // Fixed priority
    arb_request = 7'b0100110;
    step();
    chk("fp_grant1", 32'(arb_grant), 32'b0000010);
    chk("fp_idx1", 32'(grant_idx), 32'd1);
    chk("fp_busy1", 32'(busy), 32'h1);
    step();
    chk("fp_nopreempt", 32'(arb_grant), 32'b0000010);
    arb_request = 7'b0100100;
    step();
    chk("fp_release", 32'(arb_grant), 32'h0);
    chk("fp_release_busy", 32'(busy), 32'h0);
    chk("fp_idx_kept", 32'(grant_idx), 32'd1);
    step();
    chk("fp_gap", 32'(arb_grant), 32'h0);
    step();
    chk("fp_grant2", 32'(arb_grant), 32'b0000100);
    chk("fp_idx2", 32'(grant_idx), 32'd2);
    arb_request = '0;
    step();
    step();
    step();

    // Round-robin between slaves 0 and 6 (pointer currently 2)
    rr_mode     = 1'b1;
    arb_request = 7'b1000001;
    step();
    chk("rr_first", 32'(arb_grant), 32'b1000000);
    for (int r = 0; r < 4; r++) begin
      o  = (r % 2 == 0) ? 3'd6 : 3'd0;
      nx = (r % 2 == 0) ? 3'd0 : 3'd6;
      step();
      step();
      step();
      chk("rr_held", 32'(arb_grant), 32'(7'd1 << o));
      arb_request[o] = 1'b0;
      step();
      chk("rr_turn", 32'(arb_grant), 32'h0);
      arb_request[o] = 1'b1;
      step();
      chk("rr_idle", 32'(arb_grant), 32'h0);
      step();
      chk("rr_next", 32'(arb_grant), 32'(7'd1 << nx));
      chk("rr_next_idx", 32'(grant_idx), 32'(nx));
    end
    arb_request = '0;
    step();
    step();
    step();

    // Single requester in round-robin
    arb_request = 7'b0001000;
    step();
    chk("single_grant", 32'(arb_grant), 32'b0001000);
    for (int r = 0; r < 2; r++) begin
      arb_request = '0;
      step();
      chk("single_gap1", 32'(arb_grant), 32'h0);
      arb_request = 7'b0001000;
      step();
      chk("single_gap2", 32'(arb_grant), 32'h0);
      step();
      chk("single_regrant", 32'(arb_grant), 32'b0001000);
      chk("single_idx", 32'(grant_idx), 32'd3);
    end
    arb_request = '0;
    step();
    step();
    step();

    // Reset while slave 5 owns the bus
    arb_request = 7'b0100000;
    step();
    chk("rst5_grant", 32'(arb_grant), 32'b0100000);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_grant", 32'(arb_grant), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_idx", 32'(grant_idx), 32'd6);
    step();
    chk("arst_hold", 32'(arb_grant), 32'h0);
    reset = 1'b0;
    step();
    chk("post_rst_grant", 32'(arb_grant), 32'b0100000);
    chk("post_rst_idx", 32'(grant_idx), 32'd5);
    arb_request = '0;
    step();
    step();
    step();

    // Slave 2 holds its request indefinitely; slave 4 joins later
    arb_request = 7'b0000100;
    step();
    chk("wd_grant", 32'(arb_grant), 32'b0000100);
    held_ok = 1'b1;
    to_seen = 1'b0;
`ifdef ICE_ARB_WATCHDOG_EN
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) arb_request[4] = 1'b1;
      step();
      if (arb_grant !== 7'b0000100) held_ok = 1'b0;
      if (timeout_evt !== 1'b0) to_seen = 1'b1;
    end
    chk("wd_held10", 32'(held_ok), 32'h1);
    chk("wd_no_early_tevt", 32'(to_seen), 32'h0);
    step();
    chk("wd_revoked", 32'(arb_grant), 32'h0);
    chk("wd_tevt", 32'(timeout_evt), 32'h1);
    step();
    chk("wd_tevt_pulse", 32'(timeout_evt), 32'h0);
    chk("wd_turn", 32'(arb_grant), 32'h0);
    step();
    chk("wd_slave4", 32'(arb_grant), 32'b0010000);
    chk("wd_slave4_idx", 32'(grant_idx), 32'd4);
    arb_request[4] = 1'b0;
    step();
    chk("wd_s4_turn", 32'(arb_grant), 32'h0);
    step();
    chk("wd_s4_idle", 32'(arb_grant), 32'h0);
    step();
    chk("wd_locked", 32'(arb_grant), 32'h0);
    arb_request[2] = 1'b0;
    step();
    chk("wd_unlock", 32'(arb_grant), 32'h0);
    arb_request[2] = 1'b1;
    step();
    chk("wd_regrant", 32'(arb_grant), 32'b0000100);
`else
    for (int i = 1; i <= 1000; i++) begin
      if (i == 3) arb_request[4] = 1'b1;
      step();
      if (arb_grant !== 7'b0000100) held_ok = 1'b0;
      if (timeout_evt !== 1'b0) to_seen = 1'b1;
    end
    chk("nowd_held", 32'(held_ok), 32'h1);
    chk("nowd_no_tevt", 32'(to_seen), 32'h0);
    chk("nowd_idx", 32'(grant_idx), 32'd2);
`endif
    arb_request = '0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
